mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised N-requester front end for one `memory` instance (separate read and write ports, synchronous read).
- Lets several core bus masters share a single memory, e.g. instruction and data buses of two cores.
- Independent round-robin arbiters for the read channel and the write channel.
- Read data is routed back to the winning requester by a tag pipeline matched to the memory read latency.

Parameters:
- N_PORTS, 4, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- READ_LATENCY, 1, cycles from mem_r_en to valid mem_r_data (1..4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_r_en  in  N_PORTS  per-port read request
- req_r_addr  in  N_PORTS*ADDR_W  per-port read address; port k at [k*ADDR_W +: ADDR_W]
- req_w_en  in  N_PORTS  per-port write request
- req_w_addr  in  N_PORTS*ADDR_W  per-port write address
- req_w_data  in  N_PORTS*DATA_W  per-port write data
- req_r_gnt  out  N_PORTS  one-hot read grant (combinational)
- req_w_gnt  out  N_PORTS  one-hot write grant (combinational)
- req_r_valid  out  N_PORTS  one-hot read-data-valid (registered)
- req_r_data  out  DATA_W  read data, broadcast to all ports; qualified by req_r_valid
- mem_r_en  out  1  to memory r_en
- mem_r_addr  out  ADDR_W  to memory r_addr
- mem_r_data  in  DATA_W  from memory r_data
- mem_w_en  out  1  to memory w_en
- mem_w_addr  out  ADDR_W  to memory w_addr
- mem_w_data  out  DATA_W  to memory w_data

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_ptr = 0, wr_ptr = 0, tag pipeline cleared.
  - All gnt, valid, mem_r_en and mem_w_en are 0; they are forced 0 while rst_n is low.
  - req_r_data = mem_r_data passthrough; it is don't-care while valid = 0.
- Request handshake:
  - A requester raises r_en or w_en and holds address/data stable until it sees its gnt high at a rising edge.
  - The request is consumed on that edge. The requester may drop the request or issue a new one the next cycle.
  - Dropping a request before grant is legal (abort); no state changes.
- Write arbiter:
  - Grants the first requesting port searching wr_ptr, wr_ptr+1, ... mod N_PORTS.
  - mem_w_en, mem_w_addr and mem_w_data are muxed from the winner in the same cycle (0 latency).
  - On grant to port k, wr_ptr <= (k+1) mod N_PORTS. No grant means no pointer change.
- Read arbiter: same search from rd_ptr, with candidates masked by the hazard rule below.
  - mem_r_en and mem_r_addr are muxed from the winner in the same cycle.
  - rd_ptr <= (k+1) mod N_PORTS on grant.
- Same-address hazard:
  - If the read winner's address equals the address of the write granted in the same cycle, that read is not granted this cycle; the read arbiter picks the next eligible port instead.
  - A blocked port keeps priority: rd_ptr does not advance past it.
  - It is granted next cycle if no conflicting write is granted then. This guarantees reads never race a same-cycle write.
- Read return:
  - A tag pipeline READ_LATENCY stages deep carries {valid, one-hot port}.
  - req_r_valid[k] is 1 exactly READ_LATENCY cycles after the edge where req_r_gnt[k] was sampled high. req_r_data = mem_r_data in that cycle.
  - Back-to-back reads are fully pipelined: 1 read per cycle.
- One port may be granted read and write in the same cycle (different addresses).
- Fairness: a continuously requesting port waits at most N_PORTS-1 grants on its channel. A hazard stall delays but never reorders its turn.
- No requests: all gnt = 0, mem enables = 0, pointers hold.
- Reset mid-operation: in-flight tags are discarded and no valid is issued for them; the memory contents are untouched by the arbiter.
- Width rules: pointers are clog2(N_PORTS) bits and wrap modulo N_PORTS (not a power-of-two wrap when N_PORTS is not a power of 2).

Test Plan:
- Single read: N=4, LAT=1; port 2 reads 0x10 (mem holds 0xDEADBEEF) -> req_r_gnt=0100 same cycle; next cycle req_r_valid=0100, req_r_data=0xDEADBEEF.
- Round robin: all 4 ports hold read requests for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; each port gets valid once per 4 cycles.
- Hazard: port 0 writes 0x55 to 0x20 while port 1 reads 0x20 in the same cycle -> w_gnt=0001, r_gnt=0000 that cycle; next cycle r_gnt=0010; the read returns 0x55.
- Concurrent channels: port 3 reads 0x04 while port 1 writes 0x08 -> both granted the same cycle; wr_ptr=2, rd_ptr=0 afterwards.
- Latency/pipelining: LAT=3, ports 0 and 1 read on consecutive cycles -> valid=0001 at t+3, 0010 at t+4, data matches each address.
- Reset mid-flight: LAT=2, assert rst_n low 1 cycle after a read grant -> no req_r_valid ever appears; pointers read back 0; the first grant after reset goes to the lowest requesting port.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// N-requester front end for a single memory with separate read/write ports.
// Independent round-robin arbiters per channel; read data is steered back by a tag pipeline.
module mem_port_arbiter #(
  parameter int unsigned N_PORTS      = 4,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          req_r_en,
  input  logic [N_PORTS*ADDR_W-1:0]   req_r_addr,
  input  logic [N_PORTS-1:0]          req_w_en,
  input  logic [N_PORTS*ADDR_W-1:0]   req_w_addr,
  input  logic [N_PORTS*DATA_W-1:0]   req_w_data,
  output logic [N_PORTS-1:0]          req_r_gnt,
  output logic [N_PORTS-1:0]          req_w_gnt,
  output logic [N_PORTS-1:0]          req_r_valid,
  output logic [DATA_W-1:0]           req_r_data,
  output logic                        mem_r_en,
  output logic [ADDR_W-1:0]           mem_r_addr,
  input  logic [DATA_W-1:0]           mem_r_data,
  output logic                        mem_w_en,
  output logic [ADDR_W-1:0]           mem_w_addr,
  output logic [DATA_W-1:0]           mem_w_data
);

  localparam int unsigned PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t w_idx, r_idx, blk_idx;
  ptr_t w_cand, r_cand;
  logic w_any, r_any, blk_any;

  logic [ADDR_W-1:0] r_addr_a [N_PORTS];
  logic [ADDR_W-1:0] w_addr_a [N_PORTS];
  logic [DATA_W-1:0] w_data_a [N_PORTS];
  logic [N_PORTS-1:0] tag_q [READ_LATENCY];

  // Modulo-N_PORTS wrap, correct for non-power-of-two port counts.
  function automatic ptr_t rot(input ptr_t base, input int unsigned off);
    logic [PTR_W:0] s;
    s = {1'b0, base} + (PTR_W+1)'(off);
    if (s >= (PTR_W+1)'(N_PORTS)) s = s - (PTR_W+1)'(N_PORTS);
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      r_addr_a[k] = req_r_addr[k*ADDR_W +: ADDR_W];
      w_addr_a[k] = req_w_addr[k*ADDR_W +: ADDR_W];
      w_data_a[k] = req_w_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_any  = 1'b0;
    w_idx  = '0;
    w_cand = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      w_cand = rot(wr_ptr_q, i);
      if (!w_any && req_w_en[w_cand]) begin
        w_any = 1'b1;
        w_idx = w_cand;
      end
    end
    w_any    = w_any & rst_n;
    wr_ptr_d = w_any ? rot(w_idx, 1) : wr_ptr_q;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      req_w_gnt[k] = w_any && (w_idx == ptr_t'(k));
    end
  end

  assign mem_w_en   = w_any;
  assign mem_w_addr = w_addr_a[w_idx];
  assign mem_w_data = w_data_a[w_idx];

  // A read colliding with this cycle's write is skipped; the first such port
  // becomes the new pointer so it keeps its turn for the next cycle.
  always_comb begin
    r_any   = 1'b0;
    r_idx   = '0;
    blk_any = 1'b0;
    blk_idx = '0;
    r_cand  = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      r_cand = rot(rd_ptr_q, i);
      if (!r_any && req_r_en[r_cand]) begin
        if (w_any && (r_addr_a[r_cand] == mem_w_addr)) begin
          if (!blk_any) begin
            blk_any = 1'b1;
            blk_idx = r_cand;
          end
        end else begin
          r_any = 1'b1;
          r_idx = r_cand;
        end
      end
    end
    r_any = r_any & rst_n;
    if (!r_any)       rd_ptr_d = rd_ptr_q;
    else if (blk_any) rd_ptr_d = blk_idx;
    else              rd_ptr_d = rot(r_idx, 1);
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      req_r_gnt[k] = r_any && (r_idx == ptr_t'(k));
    end
  end

  assign mem_r_en   = r_any;
  assign mem_r_addr = r_addr_a[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      tag_q[0] <= req_r_gnt;
      for (int unsigned i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign req_r_valid = tag_q[READ_LATENCY-1];
  assign req_r_data  = mem_r_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (read latency 1, 2, 3) share one stimulus and a behavioural memory.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_r_en, req_w_en;
  logic [127:0] req_r_addr, req_w_addr, req_w_data;

  logic [3:0]  r_gnt1, w_gnt1, val1, r_gnt2, w_gnt2, val2, r_gnt3, w_gnt3, val3;
  logic [31:0] rdat1, rdat2, rdat3, mr_addr1, mr_addr2, mr_addr3;
  logic [31:0] mw_addr1, mw_addr2, mw_addr3, mw_data1, mw_data2, mw_data3;
  logic [31:0] mr_data1, mr_data2, mr_data3;
  logic        mr_en1, mr_en2, mr_en3, mw_en1, mw_en2, mw_en3;

  logic [31:0] mem [256];
  logic [31:0] p2a, p3a, p3b;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N_PORTS(4), .ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_r_en(req_r_en), .req_r_addr(req_r_addr),
    .req_w_en(req_w_en), .req_w_addr(req_w_addr), .req_w_data(req_w_data),
    .req_r_gnt(r_gnt1), .req_w_gnt(w_gnt1), .req_r_valid(val1), .req_r_data(rdat1),
    .mem_r_en(mr_en1), .mem_r_addr(mr_addr1), .mem_r_data(mr_data1),
    .mem_w_en(mw_en1), .mem_w_addr(mw_addr1), .mem_w_data(mw_data1));

  mem_port_arbiter #(.N_PORTS(4), .ADDR_W(32), .DATA_W(32), .READ_LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req_r_en(req_r_en), .req_r_addr(req_r_addr),
    .req_w_en(req_w_en), .req_w_addr(req_w_addr), .req_w_data(req_w_data),
    .req_r_gnt(r_gnt2), .req_w_gnt(w_gnt2), .req_r_valid(val2), .req_r_data(rdat2),
    .mem_r_en(mr_en2), .mem_r_addr(mr_addr2), .mem_r_data(mr_data2),
    .mem_w_en(mw_en2), .mem_w_addr(mw_addr2), .mem_w_data(mw_data2));

  mem_port_arbiter #(.N_PORTS(4), .ADDR_W(32), .DATA_W(32), .READ_LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_r_en(req_r_en), .req_r_addr(req_r_addr),
    .req_w_en(req_w_en), .req_w_addr(req_w_addr), .req_w_data(req_w_data),
    .req_r_gnt(r_gnt3), .req_w_gnt(w_gnt3), .req_r_valid(val3), .req_r_data(rdat3),
    .mem_r_en(mr_en3), .mem_r_addr(mr_addr3), .mem_r_data(mr_data3),
    .mem_w_en(mw_en3), .mem_w_addr(mw_addr3), .mem_w_data(mw_data3));

  // Behavioural synchronous memory; all arbiters see identical stimulus so u1's write port drives it.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = 32'hA000_0000;
    mem[8'h04] = 32'hA000_0001;
    mem[8'h08] = 32'hA000_0002;
    mem[8'h0C] = 32'hA000_0003;
    mem[8'h10] = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (mw_en1) mem[mw_addr1[7:0]] <= mw_data1;
    mr_data1 <= mem[mr_addr1[7:0]];
    p2a      <= mem[mr_addr2[7:0]];
    mr_data2 <= p2a;
    p3a      <= mem[mr_addr3[7:0]];
    p3b      <= p3a;
    mr_data3 <= p3b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_all();
    req_r_en = '0; req_w_en = '0;
    req_r_addr = '0; req_w_addr = '0; req_w_data = '0;
  endtask

  task automatic set_r(input int p, input logic [31:0] a);
    req_r_en[p] = 1'b1;
    req_r_addr[p*32 +: 32] = a;
  endtask

  task automatic set_w(input int p, input logic [31:0] a, input logic [31:0] d);
    req_w_en[p] = 1'b1;
    req_w_addr[p*32 +: 32] = a;
    req_w_data[p*32 +: 32] = d;
  endtask

  task automatic do_reset();
    clr_all();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_all();
    set_r(0, 32'h0);
    set_w(1, 32'h8, 32'h1);
    @(negedge clk);
    checks++;
    if (r_gnt1 !== 4'b0 || w_gnt1 !== 4'b0) begin
      errors++; $display("FAIL reset_gnt got r=%b w=%b exp 0000", r_gnt1, w_gnt1);
    end
    checks++;
    if (mr_en1 !== 1'b0 || mw_en1 !== 1'b0) begin
      errors++; $display("FAIL reset_en got r=%b w=%b exp 0", mr_en1, mw_en1);
    end
    checks++;
    if (val1 !== 4'b0 || val2 !== 4'b0 || val3 !== 4'b0) begin
      errors++; $display("FAIL reset_valid got %b %b %b exp 0000", val1, val2, val3);
    end
    checks++;
    if (u1.rd_ptr_q !== 2'd0 || u1.wr_ptr_q !== 2'd0) begin
      errors++; $display("FAIL reset_ptr got rd=%0d wr=%0d exp 0", u1.rd_ptr_q, u1.wr_ptr_q);
    end
    tick();
    clr_all();
  endtask

  task automatic test_single_read();
    do_reset();
    set_r(2, 32'h10);
    @(negedge clk);
    checks++;
    if (r_gnt1 !== 4'b0100 || mr_addr1 !== 32'h10) begin
      errors++; $display("FAIL single_gnt got %b addr %h exp 0100 addr 10", r_gnt1, mr_addr1);
    end
    tick();
    clr_all();
    @(negedge clk);
    checks++;
    if (val1 !== 4'b0100) begin
      errors++; $display("FAIL single_valid got %b exp 0100", val1);
    end
    checks++;
    if (rdat1 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_data got %h exp deadbeef", rdat1);
    end
    checks++;
    if (r_gnt1 !== 4'b0 || mr_en1 !== 1'b0) begin
      errors++; $display("FAIL idle_gnt got %b en %b exp 0000 0", r_gnt1, mr_en1);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g, exp_v;
    do_reset();
    for (int k = 0; k < 4; k++) set_r(k, 32'(k*4));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_g = 4'b0001 << (c % 4);
      checks++;
      if (r_gnt1 !== exp_g) begin
        errors++; $display("FAIL rr_gnt c=%0d got %b exp %b", c, r_gnt1, exp_g);
      end
      if (c > 0) begin
        exp_v = 4'b0001 << ((c - 1) % 4);
        checks++;
        if (val1 !== exp_v || rdat1 !== (32'hA000_0000 + 32'((c - 1) % 4))) begin
          errors++;
          $display("FAIL rr_valid c=%0d got %b %h exp %b %h", c, val1, rdat1, exp_v,
                   32'hA000_0000 + 32'((c - 1) % 4));
        end
      end
      tick();
    end
    clr_all();
    @(negedge clk);
    checks++;
    if (val1 !== 4'b1000 || rdat1 !== 32'hA000_0003) begin
      errors++; $display("FAIL rr_last got %b %h exp 1000 a0000003", val1, rdat1);
    end
    tick();
  endtask

  task automatic test_hazard();
    do_reset();
    set_w(0, 32'h20, 32'h55);
    set_r(1, 32'h20);
    @(negedge clk);
    checks++;
    if (w_gnt1 !== 4'b0001 || r_gnt1 !== 4'b0000 || mr_en1 !== 1'b0) begin
      errors++; $display("FAIL hazard_block got w=%b r=%b en=%b exp 0001 0000 0", w_gnt1, r_gnt1, mr_en1);
    end
    tick();
    req_w_en = '0;
    @(negedge clk);
    checks++;
    if (r_gnt1 !== 4'b0010) begin
      errors++; $display("FAIL hazard_retry got %b exp 0010", r_gnt1);
    end
    tick();
    clr_all();
    @(negedge clk);
    checks++;
    if (val1 !== 4'b0010 || rdat1 !== 32'h55) begin
      errors++; $display("FAIL hazard_data got %b %h exp 0010 00000055", val1, rdat1);
    end
    tick();
    // blocked port 1 must keep its turn while port 2 is served
    do_reset();
    set_w(0, 32'h24, 32'h66);
    set_r(1, 32'h24);
    set_r(2, 32'h30);
    @(negedge clk);
    checks++;
    if (r_gnt1 !== 4'b0100 || w_gnt1 !== 4'b0001) begin
      errors++; $display("FAIL hazard_skip got r=%b w=%b exp 0100 0001", r_gnt1, w_gnt1);
    end
    tick();
    req_w_en = '0;
    req_r_en[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (u1.rd_ptr_q !== 2'd1 || r_gnt1 !== 4'b0010) begin
      errors++; $display("FAIL hazard_keep got ptr=%0d gnt=%b exp 1 0010", u1.rd_ptr_q, r_gnt1);
    end
    tick();
    clr_all();
    @(negedge clk);
    checks++;
    if (val1 !== 4'b0010 || rdat1 !== 32'h66) begin
      errors++; $display("FAIL hazard_keep_data got %b %h exp 0010 00000066", val1, rdat1);
    end
    tick();
  endtask

  task automatic test_concurrent();
    do_reset();
    set_r(3, 32'h04);
    set_w(1, 32'h08, 32'h77);
    @(negedge clk);
    checks++;
    if (r_gnt1 !== 4'b1000 || w_gnt1 !== 4'b0010) begin
      errors++; $display("FAIL conc_gnt got r=%b w=%b exp 1000 0010", r_gnt1, w_gnt1);
    end
    checks++;
    if (mw_addr1 !== 32'h08 || mw_data1 !== 32'h77 || mr_addr1 !== 32'h04) begin
      errors++; $display("FAIL conc_mux got wa=%h wd=%h ra=%h exp 8 77 4", mw_addr1, mw_data1, mr_addr1);
    end
    tick();
    clr_all();
    @(negedge clk);
    checks++;
    if (u1.wr_ptr_q !== 2'd2 || u1.rd_ptr_q !== 2'd0) begin
      errors++; $display("FAIL conc_ptr got wr=%0d rd=%0d exp 2 0", u1.wr_ptr_q, u1.rd_ptr_q);
    end
    checks++;
    if (val1 !== 4'b1000 || rdat1 !== 32'hA000_0001) begin
      errors++; $display("FAIL conc_data got %b %h exp 1000 a0000001", val1, rdat1);
    end
    tick();
  endtask

  task automatic test_latency();
    do_reset();
    set_r(0, 32'h00);
    set_r(1, 32'h04);
    @(negedge clk);
    checks++;
    if (r_gnt3 !== 4'b0001) begin
      errors++; $display("FAIL lat_gnt0 got %b exp 0001", r_gnt3);
    end
    tick();
    req_r_en[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (r_gnt3 !== 4'b0010 || val3 !== 4'b0) begin
      errors++; $display("FAIL lat_gnt1 got %b valid %b exp 0010 0000", r_gnt3, val3);
    end
    tick();
    clr_all();
    @(negedge clk);
    checks++;
    if (val3 !== 4'b0) begin
      errors++; $display("FAIL lat_early got %b exp 0000", val3);
    end
    tick();
    @(negedge clk);
    checks++;
    if (val3 !== 4'b0001 || rdat3 !== 32'hA000_0000) begin
      errors++; $display("FAIL lat_ret0 got %b %h exp 0001 a0000000", val3, rdat3);
    end
    tick();
    @(negedge clk);
    checks++;
    if (val3 !== 4'b0010 || rdat3 !== 32'hA000_0001) begin
      errors++; $display("FAIL lat_ret1 got %b %h exp 0010 a0000001", val3, rdat3);
    end
    tick();
    @(negedge clk);
    checks++;
    if (val3 !== 4'b0) begin
      errors++; $display("FAIL lat_tail got %b exp 0000", val3);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_r(0, 32'h00);
    @(negedge clk);
    checks++;
    if (r_gnt2 !== 4'b0001) begin
      errors++; $display("FAIL mid_gnt got %b exp 0001", r_gnt2);
    end
    tick();
    clr_all();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (val2 !== 4'b0) begin
      errors++; $display("FAIL mid_valid_rst got %b exp 0000", val2);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (val2 !== 4'b0) begin
        errors++; $display("FAIL mid_valid c=%0d got %b exp 0000", c, val2);
      end
      tick();
    end
    checks++;
    if (u2.rd_ptr_q !== 2'd0 || u2.wr_ptr_q !== 2'd0) begin
      errors++; $display("FAIL mid_ptr got rd=%0d wr=%0d exp 0", u2.rd_ptr_q, u2.wr_ptr_q);
    end
    set_r(3, 32'h0C);
    set_r(1, 32'h04);
    @(negedge clk);
    checks++;
    if (r_gnt2 !== 4'b0010) begin
      errors++; $display("FAIL mid_first got %b exp 0010", r_gnt2);
    end
    tick();
    clr_all();
  endtask

  initial begin
    clr_all();
    test_reset();
    test_single_read();
    test_round_robin();
    test_hazard();
    test_concurrent();
    test_latency();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
